// File: rtl/ipsxe_floating_point_vec_ctrl_pkg.sv
// Shared types for the FP test-vector sequencer.
// Build option: IPSXE_FLOATING_POINT_NAN_CMP_EN (NaN-aware compare).
package ipsxe_floating_point_ctrl_pkg;

  localparam int CNT_W  = 5;
  localparam int ADDR_W = 4;
  localparam int TMO_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RES,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic int fp_width(
    input int exp_w,
    input int man_w
  );
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_vec_ctrl_if.sv
// Operand issue / result return handshake between
// the vector sequencer (master) and the FP core (slave).
interface ipsxe_floating_point_vec_ctrl_if
  import ipsxe_floating_point_ctrl_pkg::*;
#(
  parameter int W = fp_width(8, 23)
);

  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic [W-1:0] res_data;

  modport master (
    output op_valid,
    output op_a,
    output op_b,
    input  op_ready,
    input  res_valid,
    input  res_data
  );

  modport slave (
    input  op_valid,
    input  op_a,
    input  op_b,
    output op_ready,
    output res_valid,
    output res_data
  );

endinterface

// File: rtl/ipsxe_floating_point_res_cmp.sv
// Result-vs-expected compare; bit-exact by default, NaN-equivalent
// when IPSXE_FLOATING_POINT_NAN_CMP_EN is defined.
module ipsxe_floating_point_res_cmp
  import ipsxe_floating_point_ctrl_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MAN_WIDTH:0] res,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] exp_word,
  output logic                         match
);

  localparam int W = fp_width(EXP_WIDTH, MAN_WIDTH);

`ifdef IPSXE_FLOATING_POINT_NAN_CMP_EN
  logic res_nan;
  logic exp_nan;

  // any NaN equals any NaN: sign and payload are ignored
  assign res_nan = (&res[W-2:MAN_WIDTH])
                 & (|res[MAN_WIDTH-1:0]);
  assign exp_nan = (&exp_word[W-2:MAN_WIDTH])
                 & (|exp_word[MAN_WIDTH-1:0]);
  assign match   = (res == exp_word)
                 | (res_nan & exp_nan);
`else
  assign match = (res[W-1:0] == exp_word[W-1:0]);
`endif

endmodule

// File: rtl/ipsxe_floating_point_vec_ctrl.sv
// FP test-vector sequencer: walks the ROMs, issues operands, checks results.
// Build option: IPSXE_FLOATING_POINT_NAN_CMP_EN (NaN-aware compare).
module ipsxe_floating_point_vec_ctrl
  import ipsxe_floating_point_ctrl_pkg::*;
#(
  parameter int EXP_WIDTH   = 8,
  parameter int MAN_WIDTH   = 23,
  parameter int NUM_VECTORS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [ADDR_W-1:0]            rom_rd_addr,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] rom_a_dout,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] rom_b_dout,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] rom_exp_dout,
  ipsxe_floating_point_vec_ctrl_if.master core,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             fail_cnt,
  output logic                         timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_VECTORS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [TMO_W-1:0]  tmo;
  logic              match;
  logic              hit;
  logic              skip;
  logic              accept;
  logic              expired;

  ipsxe_floating_point_res_cmp #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_cmp (
    .res      (core.res_data),
    .exp_word (rom_exp_dout),
    .match    (match)
  );

  assign accept  = core.op_valid & core.op_ready;
  assign expired = (tmo == TMO_LAST);

  assign rom_rd_addr   = idx;
  assign core.op_valid = (state == S_ISSUE);
  assign core.op_a     = rom_a_dout;
  assign core.op_b     = rom_b_dout;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_ISSUE;
      S_ISSUE:    if (accept) state_nxt = S_WAIT_RES;
      S_WAIT_RES: if (core.res_valid || expired)
                    state_nxt = S_CHECK;
      S_CHECK:    state_nxt = (idx == LAST_IDX) ?
                              S_DONE : S_FETCH;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      tmo         <= '0;
      hit         <= 1'b0;
      skip        <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx         <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            tmo  <= '0;
            hit  <= 1'b0;
            skip <= 1'b0;
          end
        end
        S_WAIT_RES: begin
          if (core.res_valid) begin
            hit <= match;
          end else if (expired) begin
            // timed-out vector is charged here; CHECK must not recount it
            skip        <= 1'b1;
            fail_cnt    <= fail_cnt + CNT_W'(1);
            timeout_err <= 1'b1;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        S_CHECK: begin
          if (!skip) begin
            if (hit) pass_cnt <= pass_cnt + CNT_W'(1);
            else     fail_cnt <= fail_cnt + CNT_W'(1);
          end
          if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
